// File: rtl/output_limit_pkg.sv
// Shared defaults and constants for the output-limit FIFO slice.
package output_limit_pkg;

    localparam int unsigned DEF_WIDTH      = 16;
    localparam int unsigned DEF_DEPTH_LOG2 = 11;
    localparam int unsigned DEF_LIMIT_W    = 16;
    localparam int unsigned LIMIT_MAX      = (1 << DEF_LIMIT_W) - 1;
    localparam int unsigned STATS_W        = 32;

endpackage

// File: rtl/output_limit_fifo_if.sv
// Application write side, host limit control and FWFT read side of the output FIFO.
interface output_limit_fifo_if
    import output_limit_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned LIMIT_W = DEF_LIMIT_W
) ();

    logic [WIDTH-1:0]   din;
    logic               wr_en;
    logic               full;
    logic               mode_limit;
    logic               reg_output_limit;
    logic [LIMIT_W-1:0] output_limit;
    logic               output_limit_done;
    logic [WIDTH-1:0]   dout;
    logic               rd_en;
    logic               empty;
    logic               err_overflow;
    logic [STATS_W-1:0] words_out;

    modport master (
        output din, wr_en, mode_limit, reg_output_limit, rd_en,
        input  full, output_limit, output_limit_done, dout, empty, err_overflow, words_out
    );

    modport slave (
        input  din, wr_en, mode_limit, reg_output_limit, rd_en,
        output full, output_limit, output_limit_done, dout, empty, err_overflow, words_out
    );

endinterface

// File: rtl/fifo_fwft_sync.sv
// Single-clock FIFO: dual-port RAM with a registered read port acting as the FWFT head stage.
module fifo_fwft_sync
    import output_limit_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      din_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic [DEPTH_LOG2:0]   fill_o,
    output logic                  full_o,
    output logic                  empty_nxt_c
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned FILL_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]     mem_cnt_q, mem_cnt_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic                  full_q, full_d;
    logic                  valid_q, valid_d;
    logic [WIDTH-1:0]      dout_q;
    logic                  fetch;

    // Refill the head register whenever it is free or being consumed.
    always_comb begin
        fetch     = (mem_cnt_q != '0) & (~valid_q | pop_i);
        wr_ptr_d  = wr_ptr_q + DEPTH_LOG2'(push_i);
        rd_ptr_d  = rd_ptr_q + DEPTH_LOG2'(fetch);
        mem_cnt_d = mem_cnt_q + FILL_W'(push_i) - FILL_W'(fetch);
        fill_d    = fill_q + FILL_W'(push_i) - FILL_W'(pop_i);
        valid_d   = fetch | (valid_q & ~pop_i);
        full_d    = (fill_d == FILL_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            fill_q    <= '0;
            full_q    <= 1'b0;
            valid_q   <= 1'b0;
            dout_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            fill_q    <= fill_d;
            full_q    <= full_d;
            valid_q   <= valid_d;
            if (fetch) begin
                dout_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign dout_o      = dout_q;
    assign fill_o      = fill_q;
    assign full_o      = full_q;
    assign empty_nxt_c = ~valid_d;

endmodule

// File: rtl/output_limit_fifo.sv
// Output FIFO toward the USB I/O stage; in limit mode only a host-snapshotted word count is exposed.
// Optional delivered-word counter enabled by OUTPUT_LIMIT_STATS_EN.
module output_limit_fifo
    import output_limit_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int unsigned LIMIT_W    = DEF_LIMIT_W
) (
    input  logic                IFCLK,
    input  logic                rst_n,
    output_limit_fifo_if.slave  bus
);

    localparam int unsigned FILL_W = DEPTH_LOG2 + 1;
    // One spare bit keeps the saturation compare meaningful for any width pairing.
    localparam int unsigned CMP_W  = ((FILL_W > LIMIT_W) ? FILL_W : LIMIT_W) + 1;
    localparam logic [LIMIT_W-1:0] LIM_MAX = '1;

    logic [FILL_W-1:0]  fill;
    logic               fifo_full;
    logic               raw_empty_nxt;
    logic [WIDTH-1:0]   fifo_dout;

    logic               push, pop, snap_req, mode_rise;
    logic [CMP_W-1:0]   avail;
    logic [LIMIT_W-1:0] snap;

    logic               mode_q;
    logic [LIMIT_W-1:0] remaining_q, remaining_d;
    logic [LIMIT_W-1:0] limit_q, limit_d;
    logic               empty_q, empty_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    assign push      = bus.wr_en & ~fifo_full;
    assign pop       = bus.rd_en & ~empty_q;
    assign snap_req  = bus.reg_output_limit & bus.mode_limit;
    assign mode_rise = bus.mode_limit & ~mode_q;

    fifo_fwft_sync #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk         (IFCLK),
        .rst_n       (rst_n),
        .din_i       (bus.din),
        .push_i      (push),
        .pop_i       (pop),
        .dout_o      (fifo_dout),
        .fill_o      (fill),
        .full_o      (fifo_full),
        .empty_nxt_c (raw_empty_nxt)
    );

    // Snapshot excludes the word popped this cycle; words written now land after it.
    always_comb begin
        avail       = CMP_W'(fill) - CMP_W'(pop);
        snap        = (avail > CMP_W'(LIM_MAX)) ? LIM_MAX : LIMIT_W'(avail);
        remaining_d = remaining_q;
        limit_d     = limit_q;
        if (snap_req) begin
            remaining_d = snap;
            limit_d     = snap;
        end else if (mode_rise) begin
            remaining_d = '0;
        end else if (pop && bus.mode_limit && (remaining_q != '0)) begin
            remaining_d = remaining_q - LIMIT_W'(1);
        end
        empty_d = raw_empty_nxt | (bus.mode_limit & (remaining_d == '0));
        done_d  = (remaining_d == '0);
        err_d   = err_q | (bus.wr_en & fifo_full);
    end

    always_ff @(posedge IFCLK or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= 1'b0;
            remaining_q <= '0;
            limit_q     <= '0;
            empty_q     <= 1'b1;
            done_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            mode_q      <= bus.mode_limit;
            remaining_q <= remaining_d;
            limit_q     <= limit_d;
            empty_q     <= empty_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef OUTPUT_LIMIT_STATS_EN
    logic [STATS_W-1:0] words_q, words_d;

    always_comb begin
        words_d = (snap_req ? '0 : words_q) + STATS_W'(pop);
    end

    always_ff @(posedge IFCLK or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign bus.words_out = words_q;
`else
    assign bus.words_out = '0;
`endif

    assign bus.full              = fifo_full;
    assign bus.dout              = fifo_dout;
    assign bus.empty             = empty_q;
    assign bus.output_limit      = limit_q;
    assign bus.output_limit_done = done_q;
    assign bus.err_overflow      = err_q;

endmodule

// File: tb/tb_output_limit_fifo.sv
// Directed bench for output_limit_fifo: default-depth instance plus a 16-deep instance for overflow.
module tb_output_limit_fifo;

    logic IFCLK;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cnt;
    int   bad;
    int   n;
    int   gaps;

    output_limit_fifo_if ifa ();
    output_limit_fifo_if ifb ();

    output_limit_fifo u_dut (
        .IFCLK (IFCLK),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    output_limit_fifo #(
        .DEPTH_LOG2 (4)
    ) u_small (
        .IFCLK (IFCLK),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial IFCLK = 1'b0;
    always #5 IFCLK = ~IFCLK;

    task automatic tick();
        @(posedge IFCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wexp(input int k);
`ifdef OUTPUT_LIMIT_STATS_EN
        return 32'(k);
`else
        return 32'(k * 0);
`endif
    endfunction

    task automatic write_run(input logic [15:0] base, input int num);
        for (int i = 0; i < num; i++) begin
            ifa.wr_en = 1'b1;
            ifa.din   = 16'(base + 16'(i));
            tick();
        end
        ifa.wr_en = 1'b0;
    endtask

    task automatic snap_pulse();
        ifa.reg_output_limit = 1'b1;
        tick();
        ifa.reg_output_limit = 1'b0;
    endtask

    task automatic pop_run(input logic [15:0] base, input int budget, output int got, output int wrong);
        got   = 0;
        wrong = 0;
        ifa.rd_en = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (!ifa.empty) begin
                if (ifa.dout !== 16'(base + 16'(got))) wrong++;
                got++;
            end
            tick();
        end
        ifa.rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ifa.din = '0; ifa.wr_en = 1'b0; ifa.mode_limit = 1'b0; ifa.reg_output_limit = 1'b0; ifa.rd_en = 1'b0;
        ifb.din = '0; ifb.wr_en = 1'b0; ifb.mode_limit = 1'b0; ifb.reg_output_limit = 1'b0; ifb.rd_en = 1'b0;
        repeat (2) tick();

        chk("rst_full",  32'(ifa.full), 32'd0);
        chk("rst_empty", 32'(ifa.empty), 32'd1);
        chk("rst_limit", 32'(ifa.output_limit), 32'd0);
        chk("rst_done",  32'(ifa.output_limit_done), 32'd1);
        chk("rst_err",   32'(ifa.err_overflow), 32'd0);
        chk("rst_words", ifa.words_out, 32'd0);
        rst_n = 1'b1;
        tick();

        // Pass-through: ten words streamed with rd_en held high.
        ifa.rd_en = 1'b1;
        n = 0;
        gaps = 0;
        for (int c = 0; c < 30; c++) begin
            ifa.wr_en = (c < 10);
            ifa.din   = 16'(c + 1);
            tick();
            if (!ifa.empty) begin
                chk("pt_data", 32'(ifa.dout), 32'(n + 1));
                n++;
            end else if (n > 0 && n < 10) begin
                gaps++;
            end
        end
        ifa.wr_en = 1'b0;
        ifa.rd_en = 1'b0;
        chk("pt_count", 32'(n), 32'd10);
        chk("pt_gaps",  32'(gaps), 32'd0);
        chk("pt_empty", 32'(ifa.empty), 32'd1);

        // Limit snapshot of 300 with 50 extra words written afterwards.
        ifa.mode_limit = 1'b1;
        tick();
        write_run(16'h0100, 300);
        tick();
        chk("lim_hidden", 32'(ifa.empty), 32'd1);
        chk("lim_done0",  32'(ifa.output_limit_done), 32'd1);
        snap_pulse();
        chk("lim_300",    32'(ifa.output_limit), 32'd300);
        chk("lim_shown",  32'(ifa.empty), 32'd0);
        chk("lim_busy",   32'(ifa.output_limit_done), 32'd0);
        write_run(16'h0500, 50);
        pop_run(16'h0100, 400, cnt, bad);
        chk("lim_cnt",    32'(cnt), 32'd300);
        chk("lim_data",   32'(bad), 32'd0);
        chk("lim_empty",  32'(ifa.empty), 32'd1);
        chk("lim_done",   32'(ifa.output_limit_done), 32'd1);
        chk("lim_words",  ifa.words_out, wexp(300));
        snap_pulse();
        chk("lim_rest50", 32'(ifa.output_limit), 32'd50);
        pop_run(16'h0500, 80, cnt, bad);
        chk("rest_cnt",   32'(cnt), 32'd50);
        chk("rest_data",  32'(bad), 32'd0);

        // Snapshot in the same cycle as a pop.
        write_run(16'h0700, 10);
        snap_pulse();
        chk("co_lim10",   32'(ifa.output_limit), 32'd10);
        chk("co_head",    32'(ifa.dout), 32'h0700);
        ifa.reg_output_limit = 1'b1;
        ifa.rd_en = 1'b1;
        tick();
        ifa.reg_output_limit = 1'b0;
        chk("co_lim9",    32'(ifa.output_limit), 32'd9);
        chk("co_words1",  ifa.words_out, wexp(1));
        pop_run(16'h0701, 30, cnt, bad);
        chk("co_total",   32'(cnt + 1), 32'd10);
        chk("co_data",    32'(bad), 32'd0);
        chk("co_words",   ifa.words_out, wexp(10));
        chk("co_done",    32'(ifa.output_limit_done), 32'd1);

        // Mode toggle: leaving limit mode exposes beyond the limit; re-entering hides.
        write_run(16'h0800, 20);
        snap_pulse();
        chk("mt_lim20",   32'(ifa.output_limit), 32'd20);
        write_run(16'h0814, 10);
        ifa.mode_limit = 1'b0;
        tick();
        pop_run(16'h0800, 25, cnt, bad);
        chk("mt_exposed", 32'(cnt), 32'd25);
        chk("mt_data",    32'(bad), 32'd0);
        chk("mt_more",    32'(ifa.empty), 32'd0);
        ifa.mode_limit = 1'b1;
        tick();
        chk("mt_hide",    32'(ifa.empty), 32'd1);
        chk("mt_done",    32'(ifa.output_limit_done), 32'd1);
        repeat (5) tick();
        chk("mt_still",   32'(ifa.empty), 32'd1);
        snap_pulse();
        chk("mt_lim5",    32'(ifa.output_limit), 32'd5);
        chk("mt_shown",   32'(ifa.empty), 32'd0);
        pop_run(16'h0819, 20, cnt, bad);
        chk("mt_cnt5",    32'(cnt), 32'd5);
        chk("mt_data5",   32'(bad), 32'd0);

        // Overflow on the 16-deep instance.
        for (int i = 0; i < 16; i++) begin
            ifb.wr_en = 1'b1;
            ifb.din   = 16'(32'h0900 + i);
            tick();
            if (i == 14) chk("ov_full15", 32'(ifb.full), 32'd0);
        end
        chk("ov_full16",  32'(ifb.full), 32'd1);
        chk("ov_err16",   32'(ifb.err_overflow), 32'd0);
        ifb.din = 16'h09FF;
        tick();
        ifb.wr_en = 1'b0;
        chk("ov_err17",   32'(ifb.err_overflow), 32'd1);
        chk("ov_full17",  32'(ifb.full), 32'd1);
        ifb.rd_en = 1'b1;
        cnt = 0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (!ifb.empty) begin
                if (ifb.dout !== 16'(32'h0900 + cnt)) bad++;
                cnt++;
            end
            tick();
        end
        ifb.rd_en = 1'b0;
        chk("ov_cnt",     32'(cnt), 32'd16);
        chk("ov_data",    32'(bad), 32'd0);
        chk("ov_sticky",  32'(ifb.err_overflow), 32'd1);
        chk("ov_unfull",  32'(ifb.full), 32'd0);
        chk("ov_empty",   32'(ifb.empty), 32'd1);

        // Asynchronous reset in the middle of a burst.
        write_run(16'h0A00, 20);
        snap_pulse();
        chk("ar_lim20",   32'(ifa.output_limit), 32'd20);
        pop_run(16'h0A00, 3, cnt, bad);
        chk("ar_pre",     32'(cnt), 32'd3);
        ifa.rd_en = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_empty",   32'(ifa.empty), 32'd1);
        chk("ar_full",    32'(ifa.full), 32'd0);
        chk("ar_limit",   32'(ifa.output_limit), 32'd0);
        chk("ar_done",    32'(ifa.output_limit_done), 32'd1);
        chk("ar_words",   ifa.words_out, 32'd0);
        chk("ar_err_b",   32'(ifb.err_overflow), 32'd0);
        ifa.rd_en = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("ar_post_e",  32'(ifa.empty), 32'd1);
        chk("ar_post_l",  32'(ifa.output_limit), 32'd0);
        ifa.mode_limit = 1'b0;
        repeat (4) tick();
        chk("ar_flushed", 32'(ifa.empty), 32'd1);
        chk("ar_post_w",  ifa.words_out, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
